// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with status flags, condition evaluation and iterative multiply
// One-cycle ops finish on the edge after start; MUL runs a shift-add over WIDTH cycles.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       aluOp,
    input  logic [WIDTH-1:0] aluIn1,
    input  logic [WIDTH-1:0] aluIn2,
    input  logic [3:0]       cond,
    output logic [WIDTH-1:0] aluOut,
    output logic             done,
    output logic             busy,
    output logic [4:0]       flags,
    output logic             condTrue
);

    localparam logic [7:0] OP_AND   = 8'h01;
    localparam logic [7:0] OP_OR    = 8'h02;
    localparam logic [7:0] OP_XOR   = 8'h03;
    localparam logic [7:0] OP_ADDCU = 8'h04;
    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_ADDU  = 8'h06;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_MOV   = 8'h0D;
    localparam logic [7:0] OP_MUL   = 8'h0E;
    localparam logic [7:0] OP_NOT   = 8'h0F;
    localparam logic [7:0] OP_LOAD  = 8'h40;
    localparam logic [7:0] OP_STOR  = 8'h44;
    localparam logic [7:0] OP_LSH   = 8'h84;
    localparam logic [7:0] OP_ASHU  = 8'h86;

    // Flag bit positions inside {N,Z,F,L,C}
    localparam int FN = 4;
    localparam int FZ = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FC = 0;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [4:0]       r_flags;
    logic             r_done;
    logic             r_busy;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_imm_s;
    logic [WIDTH-1:0] w_imm_z;
    logic             w_use_imm_s;
    logic [WIDTH-1:0] w_arith_b;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_eq;
    logic             w_ltu;
    logic             w_lts;
    logic             w_sh_neg;
    logic [WIDTH:0]   w_sh_mag;
    logic             w_sh_big;
    logic [WIDTH-1:0] w_lsh;
    logic [WIDTH-1:0] w_ashu;
    logic [3:0]       w_shi_amt;
    logic [WIDTH-1:0] w_lshi;
    logic [WIDTH-1:0] w_ashui;
    logic [WIDTH-1:0] w_result;
    logic [4:0]       w_flags_next;
    logic             w_wr_out;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_acc_next;

    assign w_imm_s = {{(WIDTH-8){aluIn2[7]}}, aluIn2[7:0]};
    assign w_imm_z = {{(WIDTH-8){1'b0}}, aluIn2[7:0]};

    // ADDI, ADDUI, SUBI and CMPI all take a sign-extended immediate
    assign w_use_imm_s = (aluOp[7:4] == 4'h5) || (aluOp[7:4] == 4'h6) ||
                         (aluOp[7:4] == 4'h9) || (aluOp[7:4] == 4'hB);
    assign w_arith_b   = w_use_imm_s ? w_imm_s : aluIn2;
    assign w_cin       = (aluOp == OP_ADDCU) && r_flags[FC];

    assign w_sum  = {1'b0, aluIn1} + {1'b0, w_arith_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, aluIn1} - {1'b0, w_arith_b};

    assign w_add_ovf = (aluIn1[WIDTH-1] == w_arith_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != aluIn1[WIDTH-1]);
    assign w_sub_ovf = (aluIn1[WIDTH-1] != w_arith_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != aluIn1[WIDTH-1]);

    assign w_eq  = (aluIn1 == w_arith_b);
    assign w_ltu = (aluIn1 < w_arith_b);
    assign w_lts = ($signed(aluIn1) < $signed(w_arith_b));

    // Register shifts: signed amount, magnitude carried one bit wider so -2^(W-1) stays exact
    assign w_sh_neg = aluIn2[WIDTH-1];
    assign w_sh_mag = w_sh_neg ? ({1'b0, ~aluIn2} + (WIDTH+1)'(1)) : {1'b0, aluIn2};
    assign w_sh_big = (w_sh_mag >= (WIDTH+1)'(WIDTH));

    assign w_lsh  = w_sh_big ? '0 :
                    w_sh_neg ? (aluIn1 >> w_sh_mag) : (aluIn1 << w_sh_mag);
    assign w_ashu = w_sh_big ? (w_sh_neg ? {WIDTH{aluIn1[WIDTH-1]}} : '0) :
                    w_sh_neg ? WIDTH'($signed(aluIn1) >>> w_sh_mag) : (aluIn1 << w_sh_mag);

    assign w_shi_amt = aluIn2[3:0];
    assign w_lshi    = aluOp[0] ? (aluIn1 >> w_shi_amt) : (aluIn1 << w_shi_amt);
    assign w_ashui   = aluOp[0] ? WIDTH'($signed(aluIn1) >>> w_shi_amt) : (aluIn1 << w_shi_amt);

    always_comb begin
        w_result     = aluIn1;
        w_flags_next = r_flags;
        w_wr_out     = 1'b1;
        w_is_mul     = 1'b0;
        casez (aluOp)
            OP_AND, 8'b0001_????: begin
                w_result         = aluIn1 & ((aluOp == OP_AND) ? aluIn2 : w_imm_z);
                w_flags_next[FZ] = (w_result == '0);
            end
            OP_OR, 8'b0010_????: begin
                w_result         = aluIn1 | ((aluOp == OP_OR) ? aluIn2 : w_imm_z);
                w_flags_next[FZ] = (w_result == '0);
            end
            OP_XOR, 8'b0011_????: begin
                w_result         = aluIn1 ^ ((aluOp == OP_XOR) ? aluIn2 : w_imm_z);
                w_flags_next[FZ] = (w_result == '0);
            end
            OP_NOT: begin
                w_result         = ~aluIn1;
                w_flags_next[FZ] = (w_result == '0);
            end
            OP_ADD, 8'b0101_????: begin
                w_result         = w_sum[WIDTH-1:0];
                w_flags_next[FC] = w_sum[WIDTH];
                w_flags_next[FF] = w_add_ovf;
            end
            OP_ADDU, OP_ADDCU, 8'b0110_????: begin
                w_result         = w_sum[WIDTH-1:0];
                w_flags_next[FC] = w_sum[WIDTH];
            end
            OP_SUB, 8'b1001_????: begin
                w_result         = w_diff[WIDTH-1:0];
                w_flags_next[FC] = w_diff[WIDTH];
                w_flags_next[FF] = w_sub_ovf;
                w_flags_next[FZ] = w_eq;
                w_flags_next[FL] = w_ltu;
                w_flags_next[FN] = w_lts;
            end
            OP_CMP, 8'b1011_????: begin
                w_wr_out         = 1'b0;
                w_flags_next[FZ] = w_eq;
                w_flags_next[FL] = w_ltu;
                w_flags_next[FN] = w_lts;
            end
            OP_MOV:             w_result = aluIn2;
            8'b1101_????:       w_result = w_imm_z;
            8'b1111_????:       w_result = {aluIn2[7:0], {(WIDTH-8){1'b0}}};
            OP_LOAD, OP_STOR:   w_result = aluIn2;
            OP_LSH:             w_result = w_lsh;
            OP_ASHU:            w_result = w_ashu;
            8'b1000_000?:       w_result = w_lshi;
            8'b1000_001?:       w_result = w_ashui;
            OP_MUL:             w_is_mul = MUL_EN;
            default:            w_result = aluIn1;
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // The start edge already folds in multiplier bit 0, leaving WIDTH-1 edges in S_MUL
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_mul) begin
                            r_acc    <= aluIn2[0] ? aluIn1 : '0;
                            r_mcand  <= aluIn1 << 1;
                            r_mplier <= aluIn2 >> 1;
                            r_cnt    <= CW'(1);
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            if (w_wr_out) begin
                                r_out <= w_result;
                            end
                            r_flags <= w_flags_next;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_out   <= w_acc_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        condTrue = 1'b0;
        case (cond)
            4'h0: condTrue = r_flags[FZ];
            4'h1: condTrue = !r_flags[FZ];
            4'h2: condTrue = r_flags[FC];
            4'h3: condTrue = !r_flags[FC];
            4'h4: condTrue = !r_flags[FL] && !r_flags[FZ];
            4'h5: condTrue = r_flags[FL] || r_flags[FZ];
            4'h6: condTrue = !r_flags[FN] && !r_flags[FZ];
            4'h7: condTrue = r_flags[FN] || r_flags[FZ];
            4'h8: condTrue = r_flags[FF];
            4'h9: condTrue = !r_flags[FF];
            4'hA: condTrue = r_flags[FL];
            4'hB: condTrue = !r_flags[FL];
            4'hC: condTrue = r_flags[FN];
            4'hD: condTrue = !r_flags[FN];
            4'hE: condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    assign aluOut = r_out;
    assign done   = r_done;
    assign busy   = r_busy;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed scoreboard bench for alu_seq at WIDTH=16
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  aluOp;
    logic [15:0] aluIn1;
    logic [15:0] aluIn2;
    logic [3:0]  cond;
    logic [15:0] aluOut;
    logic        done;
    logic        busy;
    logic [4:0]  flags;
    logic        condTrue;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] exp_q[$];

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .aluOp(aluOp),
        .aluIn1(aluIn1), .aluIn2(aluIn2), .cond(cond),
        .aluOut(aluOut), .done(done), .busy(busy), .flags(flags), .condTrue(condTrue)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out"}, aluOut, e[20:5]);
            check({tag, "_flags"}, flags, e[4:0]);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eo, input logic [4:0] ef,
                          input int elat);
        int lat;
        logic [20:0] dummy;
        exp_q.push_back({eo, ef});
        aluOp = op; aluIn1 = a; aluIn2 = b; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 40);
        check({tag, "_lat"}, lat, elat);
        if (done) pop_compare(tag);
        else if (exp_q.size() != 0) dummy = exp_q.pop_front();
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    task automatic check_cond(input string tag, input logic [3:0] c, input logic e);
        cond = c;
        #1;
        check(tag, condTrue, e);
    endtask

    initial begin
        int done_cyc;
        int busy_low;
        int n_done;
        logic [20:0] dummy;

        reset = 1'b1; start = 1'b0; aluOp = '0; aluIn1 = '0; aluIn2 = '0; cond = '0;
        repeat (3) @(negedge clk);
        check("rst_out", aluOut, 16'h0000);
        check("rst_flags", flags, 5'b00000);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_ovf", 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1);
        check_cond("fs_after_add", 4'h8, 1'b1);
        run_op("add_carry", 8'h05, 16'hFFFF, 16'h0001, 16'h0000, 5'b00001, 1);
        check_cond("cs_after_add", 4'h2, 1'b1);
        run_op("addcu", 8'h04, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1);
        check_cond("cs_after_addcu", 4'h2, 1'b0);
        run_op("cmp", 8'h0B, 16'hFFFB, 16'h0007, 16'h0003, 5'b10000, 1);
        check_cond("lt_after_cmp", 4'hC, 1'b1);
        check_cond("ge_after_cmp", 4'hD, 1'b0);
        run_op("and", 8'h01, 16'hFFFF, 16'h0001, 16'h0001, 5'b10000, 1);
        check_cond("lt_after_and", 4'hC, 1'b1);
        check_cond("eq_after_and", 4'h0, 1'b0);
        run_op("sub", 8'h09, 16'h0005, 16'h0007, 16'hFFFE, 5'b10011, 1);
        check_cond("lo_after_sub", 4'hA, 1'b1);
        check_cond("hi_after_sub", 4'h4, 1'b0);
        run_op("cmpi", 8'hB0, 16'h0005, 16'h00FB, 16'hFFFE, 5'b00011, 1);
        check_cond("gt_after_cmpi", 4'h6, 1'b1);
        run_op("andi", 8'h10, 16'h1200, 16'hFFF0, 16'h0000, 5'b01011, 1);
        check_cond("eq_after_andi", 4'h0, 1'b1);
        check_cond("le_after_andi", 4'h7, 1'b1);
        run_op("lui", 8'hF0, 16'h5555, 16'h00AB, 16'hAB00, 5'b01011, 1);

        // Back-to-back: second start lands in the cycle the first done is high
        exp_q.push_back({16'h0011, 5'b01011});
        exp_q.push_back({16'h0022, 5'b01011});
        aluOp = 8'hD0; aluIn1 = 16'h0000; aluIn2 = 16'hFF11; start = 1'b1;
        @(negedge clk);
        check("b2b_done1", done, 1'b1);
        pop_compare("b2b_1");
        aluIn2 = 16'h0022;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done2", done, 1'b1);
        pop_compare("b2b_2");
        @(negedge clk);

        run_op("lsh_neg", 8'h84, 16'h8001, 16'hFFFF, 16'h4000, 5'b01011, 1);
        run_op("ashu_neg16", 8'h86, 16'h8000, 16'hFFF0, 16'hFFFF, 5'b01011, 1);
        run_op("lshi_left", 8'h80, 16'h0001, 16'h0004, 16'h0010, 5'b01011, 1);
        run_op("ashui_right", 8'h83, 16'h8000, 16'h0003, 16'hF000, 5'b01011, 1);
        run_op("lsh_big", 8'h84, 16'hFFFF, 16'h0010, 16'h0000, 5'b01011, 1);
        run_op("ashu_big_left", 8'h86, 16'hFFFF, 16'h0010, 16'h0000, 5'b01011, 1);
        run_op("unknown", 8'hC0, 16'h1234, 16'h5678, 16'h1234, 5'b01011, 1);
        run_op("load", 8'h40, 16'h1234, 16'hBEEF, 16'hBEEF, 5'b01011, 1);
        run_op("addi", 8'h50, 16'h7FFF, 16'h0001, 16'h8000, 5'b01110, 1);
        check_cond("fs_after_addi", 4'h8, 1'b1);
        check_cond("cc_after_addi", 4'h3, 1'b1);
        check_cond("uc", 4'hE, 1'b1);
        check_cond("nj", 4'hF, 1'b0);
        run_op("or", 8'h02, 16'h0000, 16'h0001, 16'h0001, 5'b00110, 1);
        check_cond("ne_after_or", 4'h1, 1'b1);
        run_op("not", 8'h0F, 16'hFFFF, 16'h0000, 16'h0000, 5'b01110, 1);

        // MUL with an ADD start injected mid-flight that must be ignored
        exp_q.push_back({16'h1230, 5'b01110});
        aluOp = 8'h0E; aluIn1 = 16'h0123; aluIn2 = 16'h0010; start = 1'b1;
        done_cyc = 0; busy_low = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (c == 5) begin
                aluOp = 8'h05; aluIn1 = 16'h0001; aluIn2 = 16'h0001;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!busy) busy_low++;
        end
        start = 1'b0;
        check("mul_busy_low_cycles", busy_low, 0);
        check("mul_lat", done_cyc, 16);
        check("mul_busy_at_done", busy, 1'b0);
        if (done) pop_compare("mul_1");
        else if (exp_q.size() != 0) dummy = exp_q.pop_front();
        @(negedge clk);
        check("mul_no_extra_done", done, 1'b0);

        run_op("mul_ffff", 8'h0E, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b01110, 16);

        // Reset in cycle 5 of a multiply aborts it without a done
        aluOp = 8'h0E; aluIn1 = 16'hFFFF; aluIn2 = 16'h0003; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_out", aluOut, 16'h0000);
        check("abort_flags", flags, 5'b00000);
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 24; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", n_done, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
